// File: rtl/wf_rr_issue_arbiter_pkg.sv
// Shared definitions for the wavefront round-robin issue arbiter.
package wf_rr_issue_arbiter_pkg;

  localparam int unsigned NUM_WF      = 40;
  localparam int unsigned WF_ID_WIDTH = 6;
  localparam logic [WF_ID_WIDTH-1:0] WF_ID_MAX = 6'd39;

  typedef logic [WF_ID_WIDTH-1:0] wf_id_t;
  typedef logic [NUM_WF-1:0]      wf_vec_t;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbHold = 1'b1
  } arb_state_e;

  // Modulo-40 increment; out-of-range inputs collapse to slot 0.
  function automatic wf_id_t wf_id_inc(input wf_id_t id);
    return (id >= WF_ID_MAX) ? '0 : wf_id_t'(id + 1'b1);
  endfunction

  function automatic wf_vec_t wf_onehot(input wf_id_t id);
    return wf_vec_t'(1) << id;
  endfunction

endpackage

// File: rtl/wf_rr_find_first.sv
// Circular first-set search over the wavefront slots, starting at start_i.
module wf_rr_find_first
  import wf_rr_issue_arbiter_pkg::*;
(
  input  logic [NUM_WF-1:0]      vec_i,
  input  logic [WF_ID_WIDTH-1:0] start_i,
  output logic                   found_o,
  output logic [WF_ID_WIDTH-1:0] idx_o
);

  logic [2*NUM_WF-1:0]    dbl;
  logic [NUM_WF-1:0]      rot;
  logic [WF_ID_WIDTH-1:0] off;
  logic [WF_ID_WIDTH:0]   sum;

  always_comb begin
    // Rotating the doubled vector puts slot start_i at bit 0.
    dbl     = {vec_i, vec_i} >> start_i;
    rot     = dbl[NUM_WF-1:0];
    found_o = 1'b0;
    off     = '0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        off     = WF_ID_WIDTH'(i);
      end
    end
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= (WF_ID_WIDTH+1)'(NUM_WF)) begin
      idx_o = WF_ID_WIDTH'(sum - (WF_ID_WIDTH+1)'(NUM_WF));
    end else begin
      idx_o = sum[WF_ID_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/wf_rr_issue_arbiter.sv
// Round-robin issue arbiter over the 40 wavefront slots; a grant is held until accepted,
// then the pointer advances past the granted slot and a new grant may load in the same cycle.
module wf_rr_issue_arbiter
  import wf_rr_issue_arbiter_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_WF-1:0]      request_i,
  input  logic                   grant_accept_i,
  output logic                   grant_valid_o,
  output logic [WF_ID_WIDTH-1:0] grant_wfid_o,
  output logic [NUM_WF-1:0]      grant_onehot_o,
  output logic [WF_ID_WIDTH-1:0] rr_ptr_o
);

  arb_state_e state_q;
  wf_id_t     rr_ptr_q;
  wf_id_t     grant_wfid_q;
  wf_vec_t    grant_onehot_q;

  wf_id_t  ptr_inc;
  wf_vec_t masked;
  logic    idle_found, acc_found;
  wf_id_t  idle_idx, acc_idx;

  assign ptr_inc = wf_id_inc(grant_wfid_q);
  // The slot just accepted must not win again in the same cycle.
  assign masked  = request_i & ~wf_onehot(grant_wfid_q);

  wf_rr_find_first u_find_idle (
    .vec_i   (request_i),
    .start_i (rr_ptr_q),
    .found_o (idle_found),
    .idx_o   (idle_idx)
  );

  wf_rr_find_first u_find_accept (
    .vec_i   (masked),
    .start_i (ptr_inc),
    .found_o (acc_found),
    .idx_o   (acc_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ArbIdle;
      rr_ptr_q       <= '0;
      grant_wfid_q   <= '0;
      grant_onehot_q <= '0;
    end else begin
      unique case (state_q)
        ArbIdle: begin
          if (idle_found) begin
            state_q        <= ArbHold;
            grant_wfid_q   <= idle_idx;
            grant_onehot_q <= wf_onehot(idle_idx);
          end
        end
        ArbHold: begin
          if (grant_accept_i) begin
            rr_ptr_q <= ptr_inc;
            if (acc_found) begin
              grant_wfid_q   <= acc_idx;
              grant_onehot_q <= wf_onehot(acc_idx);
            end else begin
              state_q        <= ArbIdle;
              grant_onehot_q <= '0;
            end
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign grant_valid_o  = (state_q == ArbHold);
  assign grant_wfid_o   = grant_wfid_q;
  assign grant_onehot_o = grant_onehot_q;
  assign rr_ptr_o       = rr_ptr_q;

endmodule

// File: tb/tb_wf_rr_issue_arbiter.sv
// Directed bench for wf_rr_issue_arbiter, followed by a short random run against a slot-scan model.
module tb_wf_rr_issue_arbiter;

  logic        clk;
  logic        rst;
  logic [39:0] request;
  logic        grant_accept;
  logic        grant_valid;
  logic [5:0]  grant_wfid;
  logic [39:0] grant_onehot;
  logic [5:0]  rr_ptr;

  int errors = 0;
  int checks = 0;

  // Reference model state for the random phase
  bit       m_valid;
  int       m_wfid;
  int       m_ptr;

  wf_rr_issue_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .request_i      (request),
    .grant_accept_i (grant_accept),
    .grant_valid_o  (grant_valid),
    .grant_wfid_o   (grant_wfid),
    .grant_onehot_o (grant_onehot),
    .rr_ptr_o       (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit v, input int id, input int ptr);
    logic [63:0] oh;
    oh = v ? (64'd1 << id) : 64'd0;
    chk({tag, ".valid"}, {63'd0, grant_valid}, {63'd0, v});
    chk({tag, ".wfid"}, {58'd0, grant_wfid}, 64'(id));
    chk({tag, ".onehot"}, {24'd0, grant_onehot}, oh);
    chk({tag, ".rr_ptr"}, {58'd0, rr_ptr}, 64'(ptr));
  endtask

  function automatic logic [39:0] bits(input int a, input int b, input int c);
    logic [39:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  function automatic void model_find(input logic [39:0] v, input int start,
                                     output bit f, output int idx);
    f   = 1'b0;
    idx = 0;
    for (int k = 0; k < 40; k++) begin
      if (!f && v[(start + k) % 40]) begin
        f   = 1'b1;
        idx = (start + k) % 40;
      end
    end
  endfunction

  initial begin
    rst = 1'b1;
    request = '0;
    grant_accept = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0);

    // Reset while holding a grant
    rst = 1'b0;
    request = bits(12, -1, -1);
    tick();
    chk_all("pre_rst_hold", 1, 12, 0);
    rst = 1'b1;
    tick();
    chk_all("rst_mid_hold", 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_all("regrant_after_rst", 1, 12, 0);
    request = '0;
    grant_accept = 1'b1;
    tick();
    chk_all("accept_to_idle", 0, 12, 13);
    grant_accept = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("reset2", 0, 0, 0);

    // Rotation over {3,7,20}
    request = bits(3, 7, 20);
    tick();
    chk_all("rot_first", 1, 3, 0);
    grant_accept = 1'b1;
    tick();
    chk_all("rot_7", 1, 7, 4);
    tick();
    chk_all("rot_20", 1, 20, 8);
    tick();
    chk_all("rot_3", 1, 3, 21);
    tick();
    chk_all("rot_7b", 1, 7, 4);
    grant_accept = 1'b0;
    request = '0;
    tick();
    chk_all("rot_hold", 1, 7, 4);
    grant_accept = 1'b1;
    tick();
    chk_all("rot_drain", 0, 7, 8);

    // Wrap-around at slot 39
    grant_accept = 1'b0;
    request = bits(38, -1, -1);
    tick();
    chk_all("wrap_g38", 1, 38, 8);
    grant_accept = 1'b1;
    request = bits(0, 39, -1);
    tick();
    chk_all("wrap_g39", 1, 39, 39);
    tick();
    chk_all("wrap_g0", 1, 0, 0);
    tick();
    chk_all("wrap_g39b", 1, 39, 1);
    grant_accept = 1'b0;
    request = '0;
    tick();
    grant_accept = 1'b1;
    tick();
    chk_all("wrap_drain", 0, 39, 0);
    grant_accept = 1'b0;

    // Grant held while request changes underneath
    request = bits(5, -1, -1);
    tick();
    chk_all("hold_g5", 1, 5, 0);
    request = bits(2, -1, -1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("hold_stable", 1, 5, 0);
    end
    grant_accept = 1'b1;
    tick();
    chk_all("hold_next2", 1, 2, 6);
    grant_accept = 1'b0;
    request = '0;
    tick();
    grant_accept = 1'b1;
    tick();
    chk_all("hold_drain", 0, 2, 3);

    // Single requester with accept held high
    request = bits(17, -1, -1);
    tick();
    chk_all("single_1", 1, 17, 3);
    tick();
    chk_all("single_0", 0, 17, 18);
    tick();
    chk_all("single_1b", 1, 17, 18);
    tick();
    chk_all("single_0b", 0, 17, 18);
    tick();
    chk_all("single_1c", 1, 17, 18);
    request = '0;
    tick();
    chk_all("single_drain", 0, 17, 18);
    tick();
    chk_all("spurious_accept", 0, 17, 18);

    // Random traffic against the model
    m_valid = 1'b0;
    m_wfid  = 17;
    m_ptr   = 18;
    for (int n = 0; n < 400; n++) begin
      logic [39:0] req;
      logic [39:0] msk;
      bit          acc, f;
      int          idx;
      req = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) req = '0;
      acc = $urandom_range(0, 3) != 0;
      request = req;
      grant_accept = acc;
      if (!m_valid) begin
        model_find(req, m_ptr, f, idx);
        if (f) begin
          m_valid = 1'b1;
          m_wfid  = idx;
        end
      end else if (acc) begin
        m_ptr = (m_wfid + 1) % 40;
        msk = req;
        msk[m_wfid] = 1'b0;
        model_find(msk, m_ptr, f, idx);
        if (f) m_wfid = idx;
        else   m_valid = 1'b0;
      end
      tick();
      chk_all("random", m_valid, m_wfid, m_ptr);
      chk("random.wfid_range", {63'd0, grant_wfid <= 6'd39}, 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
